// File: rtl/key_pkg.sv
// Shared types for the key event arbiter: event type codes and per-key FSM states.
// Optional auto-repeat is selected with KEY_REPEAT_EN (see key_press_fsm).
package key_pkg;

    typedef logic [1:0] evt_type_t;

    localparam evt_type_t EVT_SHORT  = 2'd0;
    localparam evt_type_t EVT_LONG   = 2'd1;
    localparam evt_type_t EVT_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LONG = 2'd2
    } key_fsm_e;

endpackage

// File: rtl/key_press_fsm.sv
// Per-key press classifier (SHORT/LONG, REPEAT when KEY_REPEAT_EN is defined)
// with a 1-deep pending event register feeding the arbiter.
//
// state  | meaning
// S_IDLE | key released, waiting for a press flag
// S_HELD | key pressed, counting ticks toward LONG
// S_LONG | LONG emitted, waiting for release (repeat ticks if enabled)
module key_press_fsm
    import key_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      tick_i,
    input  logic      key_flag_i,
    input  logic      key_state_i,
    input  logic      grant_i,
    output logic      pend_o,
    output evt_type_t pend_type_o,
    output logic      ovf_set_o
);

    localparam int CNT_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    key_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    evt_type_t        ptype_q, ptype_d;
    logic             evt_det;
    evt_type_t        evt_typ;
    logic             press, release_flag;

    assign press        = key_flag_i & ~key_state_i;
    assign release_flag = key_flag_i &  key_state_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ptype_q <= EVT_SHORT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_det = 1'b0;
        evt_typ = EVT_SHORT;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end
            end
            S_HELD: begin
                if (press) begin
                    cnt_d = '0;
                end else if (release_flag) begin
                    evt_det = 1'b1;
                    evt_typ = EVT_SHORT;
                    state_d = S_IDLE;
                end else if (tick_i) begin
                    if (cnt_q == CNT_W'(LONG_MS - 1)) begin
                        evt_det = 1'b1;
                        evt_typ = EVT_LONG;
                        cnt_d   = '0;
                        state_d = S_LONG;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_LONG: begin
                if (press) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (release_flag) begin
                    state_d = S_IDLE;
                end else if (tick_i) begin
`ifdef KEY_REPEAT_EN
                    if (cnt_q == CNT_W'(REPEAT_MS - 1)) begin
                        evt_det = 1'b1;
                        evt_typ = EVT_REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    if (cnt_q != CNT_W'(CNT_MAX)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // An entry leaving for the output register this cycle does not count as overwritten.
    always_comb begin
        pend_d    = pend_q & ~grant_i;
        ptype_d   = ptype_q;
        ovf_set_o = evt_det & pend_q & ~grant_i;
        if (evt_det) begin
            pend_d  = 1'b1;
            ptype_d = evt_typ;
        end
    end

    assign pend_o      = pend_q;
    assign pend_type_o = ptype_q;

endmodule

// File: rtl/key_event_arbiter.sv
// Key event arbiter top: timebase prescaler, per-key classifiers, round-robin
// arbiter and valid/ready output register. Auto-repeat enabled by KEY_REPEAT_EN.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int KEY_NUM   = 4,
    parameter int TICK_DIV  = 50_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [KEY_NUM-1:0]         key_flag_i,
    input  logic [KEY_NUM-1:0]         key_state_i,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(KEY_NUM)-1:0] evt_key_o,
    output logic [1:0]                 evt_type_o,
    output logic                       evt_ovf_o,
    input  logic                       ovf_clr_i
);

    localparam int KW = $clog2(KEY_NUM);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    function automatic logic [KW:0] rr_pick(input logic [KEY_NUM-1:0] req,
                                            input logic [KW-1:0]      ptr);
        logic [KW:0]   res;
        logic [KW-1:0] sel;
        int            idx;
        res = '0;
        // Scan downward so the surviving hit is the closest one at/after ptr.
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= KEY_NUM) idx = idx - KEY_NUM;
            sel = KW'(idx);
            if (req[sel]) res = {1'b1, sel};
        end
        return res;
    endfunction

    logic [1:0]       rst_sync_q;
    logic             rst_int;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic [KEY_NUM-1:0] pend, ovf_set, grant;
    evt_type_t        ptype [KEY_NUM];
    logic [KW-1:0]    ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [KW-1:0]    key_q, key_d;
    evt_type_t        type_q, type_d;
    logic             ovf_q, ovf_d;
    logic             load, found;
    logic [KW-1:0]    gnt_idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
        key_press_fsm #(
            .LONG_MS   (LONG_MS),
            .REPEAT_MS (REPEAT_MS)
        ) u_fsm (
            .clk_i       (clk_i),
            .rst_i       (rst_int),
            .tick_i      (tick),
            .key_flag_i  (key_flag_i[g]),
            .key_state_i (key_state_i[g]),
            .grant_i     (grant[g]),
            .pend_o      (pend[g]),
            .pend_type_o (ptype[g]),
            .ovf_set_o   (ovf_set[g])
        );
    end

    assign load             = ~valid_q | evt_ready_i;
    assign {found, gnt_idx} = rr_pick(pend, ptr_q);

    always_comb begin
        grant   = '0;
        valid_d = valid_q;
        key_d   = key_q;
        type_d  = type_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                grant[gnt_idx] = 1'b1;
                key_d          = gnt_idx;
                type_d         = ptype[gnt_idx];
                ptr_d          = (gnt_idx == KW'(KEY_NUM - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
        ovf_d = ovf_q;
        if (ovf_clr_i)    ovf_d = 1'b0;
        if (|ovf_set)     ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            presc_q <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            key_q   <= '0;
            type_q  <= EVT_SHORT;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            key_q   <= key_d;
            type_q  <= type_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_key_o   = key_q;
    assign evt_type_o  = type_q;
    assign evt_ovf_o   = ovf_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with an event scoreboard; the repeat
// scenario is selected when KEY_REPEAT_EN is defined.
module tb_key_event_arbiter;
    import key_pkg::*;

    localparam int KEY_NUM   = 4;
    localparam int TICK_DIV  = 10;
    localparam int LONG_MS   = 20;
    localparam int REPEAT_MS = 5;

    logic         clk_i       = 1'b0;
    logic         rst_i       = 1'b1;
    logic [3:0]   key_flag_i  = '0;
    logic [3:0]   key_state_i = '1;
    logic         evt_ready_i = 1'b1;
    logic         ovf_clr_i   = 1'b0;
    logic         evt_valid_o;
    logic [1:0]   evt_key_o;
    logic [1:0]   evt_type_o;
    logic         evt_ovf_o;

    key_event_arbiter #(
        .KEY_NUM   (KEY_NUM),
        .TICK_DIV  (TICK_DIV),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .key_flag_i  (key_flag_i),
        .key_state_i (key_state_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_key_o   (evt_key_o),
        .evt_type_o  (evt_type_o),
        .evt_ovf_o   (evt_ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    always #10 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0] key;
        evt_type_t  typ;
    } exp_t;

    exp_t sb_q[$];
    int   evc_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge clk_i) begin
        if (!rst_i && evt_valid_o && evt_ready_i) begin
            exp_t e;
            evc_q.push_back(cyc);
            n_tests++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_evt: got key %0d type %0d, required no event", evt_key_o, evt_type_o);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                assert ({evt_key_o, evt_type_o} === {e.key, e.typ}) else begin
                    n_fail++;
                    $error("FAIL evt_content: got key %0d type %0d, required key %0d type %0d",
                           evt_key_o, evt_type_o, e.key, e.typ);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        assert (got === req) else begin
            n_fail++;
            $error("FAIL %s: got %0d, required %0d", tag, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic flag(input logic [3:0] keys, input logic pressed);
        for (int k = 0; k < 4; k++)
            if (keys[k]) key_state_i[k] = ~pressed;
        key_flag_i = keys;
        step(1);
        key_flag_i = '0;
    endtask

    task automatic push(input int key, input evt_type_t typ);
        exp_t e;
        e.key = 2'(key);
        e.typ = typ;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step(3);
        key_state_i = '1;
        rst_i = 1'b0;
        step(4);
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, sb_q.size(), 0);
    endtask

    task automatic chk_hold(input string tag);
        @(negedge clk_i);
        chk({tag, "_valid"}, evt_valid_o, 1);
        chk({tag, "_key"},   evt_key_o, 2);
        chk({tag, "_type"},  evt_type_o, EVT_SHORT);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int c0;
        int lat;

        // Reset with random flag activity
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            #1;
            key_flag_i  = 4'($urandom);
            key_state_i = 4'($urandom);
            @(negedge clk_i);
            chk("rst_valid", evt_valid_o, 0);
            chk("rst_ovf", evt_ovf_o, 0);
        end
        @(posedge clk_i);
        #1;
        key_flag_i  = '0;
        key_state_i = '1;
        rst_i       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("post_rst_valid", evt_valid_o, 0);
            chk("post_rst_ovf", evt_ovf_o, 0);
            @(posedge clk_i);
            #1;
        end

        // Single SHORT on key0 and its latency
        evc_q.delete();
        flag(4'b0001, 1'b1);
        step(49);
        c0 = cyc;
        push(0, EVT_SHORT);
        flag(4'b0001, 1'b0);
        @(negedge clk_i);
        chk("short_lat_t1", evt_valid_o, 0);
        @(negedge clk_i);
        chk("short_lat_t2", evt_valid_o, 1);
        chk("short_lat_cyc", cyc, c0 + 2);
        @(posedge clk_i);
        #1;
        drain("short_drain", 10);
        step(20);
        chk("short_count", evc_q.size(), 1);

`ifndef KEY_REPEAT_EN
        // LONG on key1, nothing on release
        evc_q.delete();
        c0 = cyc;
        push(1, EVT_LONG);
        flag(4'b0010, 1'b1);
        step(299);
        flag(4'b0010, 1'b0);
        step(40);
        chk("long_count", evc_q.size(), 1);
        chk("long_sb_empty", sb_q.size(), 0);
        lat = (evc_q.size() > 0) ? evc_q[0] - 2 - c0 : -1;
        chk("long_lat_lo", lat >= 190, 1);
        chk("long_lat_hi", lat <= 200, 1);
`else
        // LONG then REPEAT 50 cycles apart
        do_reset();
        evc_q.delete();
        push(1, EVT_LONG);
        push(1, EVT_REPEAT);
        flag(4'b0010, 1'b1);
        step(279);
        flag(4'b0010, 1'b0);
        step(40);
        chk("rep_count", evc_q.size(), 2);
        chk("rep_sb_empty", sb_q.size(), 0);
        lat = (evc_q.size() > 1) ? evc_q[1] - evc_q[0] : -1;
        chk("rep_gap", lat, 50);

        // Reset while repeating-held: only the LONG before reset
        do_reset();
        evc_q.delete();
        push(1, EVT_LONG);
        flag(4'b0010, 1'b1);
        step(215);
        rst_i = 1'b1;
        step(3);
        rst_i = 1'b0;
        step(300);
        flag(4'b0010, 1'b0);
        step(50);
        chk("rep_rst_count", evc_q.size(), 1);
        chk("rep_rst_sb", sb_q.size(), 0);
`endif

        // Simultaneous SHORTs on keys 0,2,3 then 0,3
        do_reset();
        evc_q.delete();
        flag(4'b1101, 1'b1);
        step(10);
        push(0, EVT_SHORT);
        push(2, EVT_SHORT);
        push(3, EVT_SHORT);
        flag(4'b1101, 1'b0);
        step(10);
        chk("rr3_count", evc_q.size(), 3);
        lat = (evc_q.size() > 2) ? evc_q[2] - evc_q[0] : -1;
        chk("rr3_b2b", lat, 2);
        evc_q.delete();
        flag(4'b1001, 1'b1);
        step(10);
        push(0, EVT_SHORT);
        push(3, EVT_SHORT);
        flag(4'b1001, 1'b0);
        step(10);
        chk("rr2_count", evc_q.size(), 2);
        lat = (evc_q.size() > 1) ? evc_q[1] - evc_q[0] : -1;
        chk("rr2_b2b", lat, 1);

        // Backpressure, pending, overwrite and ovf_clr
        do_reset();
        evc_q.delete();
        evt_ready_i = 1'b0;
        push(2, EVT_SHORT);
        flag(4'b0100, 1'b1);
        step(5);
        flag(4'b0100, 1'b0);
        step(5);
        chk_hold("bp1");
        flag(4'b0100, 1'b1);
        step(5);
        flag(4'b0100, 1'b0);
        step(5);
        chk_hold("bp2");
        flag(4'b1000, 1'b1);
        step(5);
        flag(4'b1000, 1'b0);
        step(5);
        chk_hold("bp3");
        @(negedge clk_i);
        chk("bp_no_ovf", evt_ovf_o, 0);
        @(posedge clk_i);
        #1;
        flag(4'b0100, 1'b1);
        step(5);
        flag(4'b0100, 1'b0);
        step(3);
        chk_hold("bp4");
        @(negedge clk_i);
        chk("bp_ovf_set", evt_ovf_o, 1);
        @(posedge clk_i);
        #1;
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;
        @(negedge clk_i);
        chk("bp_ovf_clr", evt_ovf_o, 0);
        @(posedge clk_i);
        #1;
        push(3, EVT_SHORT);
        push(2, EVT_SHORT);
        evt_ready_i = 1'b1;
        drain("bp_drain", 20);
        step(5);
        chk("bp_count", evc_q.size(), 3);

        // Reset mid-hold discards the press
        do_reset();
        evc_q.delete();
        flag(4'b0001, 1'b1);
        step(100);
        rst_i = 1'b1;
        step(3);
        rst_i = 1'b0;
        step(5);
        flag(4'b0001, 1'b0);
        step(300);
        chk("rst_hold_count", evc_q.size(), 0);
        chk("rst_hold_valid", evt_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
